// File: rtl/adf4158_write_arbiter.sv
// Round-robin arbiter that serialises 32-bit ADF4158 register words from up to
// four requesters onto the device CLK/DATA/LE pins, with per-owner lock for atomic sequences.
`timescale 1ns/1ps

module adf4158_write_arbiter #(
    parameter int NREQ    = 3,
    parameter int CLK_DIV = 2,
    parameter int LE_HIGH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      req_ready,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           done_id,
    output logic                 adf_sclk,
    output logic                 adf_data,
    output logic                 adf_le
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] LATCH = 2'd3;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] LE_LAST  = 16'(LE_HIGH - 1);

    logic [1:0]      state;
    logic [15:0]     cnt;
    logic            sclk_hi;
    logic [4:0]      bit_idx;
    logic [31:0]     word;
    logic [1:0]      cur_id;
    logic [1:0]      last_grant;
    logic            owned;
    logic [1:0]      owner;

    logic            lock_hold;
    logic            lock_cur;
    logic            found;
    logic [NREQ-1:0] grant;
    logic [1:0]      grant_id;
    logic [31:0]     grant_word;

    // Grant selection: a locked owner excludes everyone else, otherwise round-robin.
    always_comb begin
        lock_hold  = 1'b0;
        lock_cur   = 1'b0;
        found      = 1'b0;
        grant      = '0;
        grant_id   = 2'd0;
        grant_word = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (owned && int'(owner) == i && req_lock[i])
                lock_hold = 1'b1;
            if (int'(cur_id) == i)
                lock_cur = req_lock[i];
        end
        if (lock_hold) begin
            for (int i = 0; i < NREQ; i++) begin
                if (int'(owner) == i && req_valid[i]) begin
                    found      = 1'b1;
                    grant[i]   = 1'b1;
                    grant_id   = 2'(i);
                    grant_word = req_data[32*i +: 32];
                end
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && i == (int'(last_grant) + 1 + k) % NREQ && req_valid[i]) begin
                        found      = 1'b1;
                        grant[i]   = 1'b1;
                        grant_id   = 2'(i);
                        grant_word = req_data[32*i +: 32];
                    end
                end
            end
        end
    end

    assign req_ready = (state == IDLE && rst_n) ? grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            sclk_hi    <= 1'b0;
            bit_idx    <= 5'd0;
            cur_id     <= 2'd0;
            last_grant <= 2'(NREQ - 1);
            owned      <= 1'b0;
            owner      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!lock_hold)
                        owned <= 1'b0;
                    if (found) begin
                        state      <= SHIFT;
                        cur_id     <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= 16'd0;
                        sclk_hi    <= 1'b0;
                        bit_idx    <= 5'd31;
                    end
                end
                SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= 16'd0;
                        if (!sclk_hi) begin
                            sclk_hi <= 1'b1;
                        end else begin
                            sclk_hi <= 1'b0;
                            if (bit_idx == 5'd0)
                                state <= GAP;
                            else
                                bit_idx <= bit_idx - 5'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= 16'd0;
                        state <= LATCH;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    // Ownership is decided by the owner's lock on the done cycle.
                    if (cnt == LE_LAST) begin
                        cnt   <= 16'd0;
                        state <= IDLE;
                        owned <= lock_cur;
                        owner <= cur_id;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // Shift register is datapath only: it is loaded on accept and advanced
    // at the start of each new bit, so DATA only moves while SCLK is low.
    always_ff @(posedge clk) begin
        if (state == IDLE && found)
            word <= grant_word;
        else if (state == SHIFT && cnt == DIV_LAST && sclk_hi && bit_idx != 5'd0)
            word <= {word[30:0], 1'b0};
    end

    assign busy     = (state != IDLE);
    assign done     = (state == LATCH) && (cnt == LE_LAST);
    assign done_id  = cur_id;
    assign adf_sclk = (state == SHIFT) && sclk_hi;
    assign adf_data = (state == SHIFT) && word[31];
    assign adf_le   = (state == IDLE) || (state == LATCH);

endmodule

// File: tb/tb_adf4158_write_arbiter.sv
// Self-checking bench: randomized requesters against a round-robin/lock reference
// model plus a pin-level scoreboard that rebuilds each word from SCLK/DATA/LE.
`timescale 1ns/1ps

module tb_adf4158_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = 3'b000;
    logic [2:0]  req_lock = 3'b000;
    logic [31:0] dw [3];
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        busy, done, adf_sclk, adf_data, adf_le;
    logic [1:0]  done_id;

    logic [2:0]  f_req_valid = 3'b000;
    logic [31:0] fdw = 32'd0;
    logic [95:0] f_req_data;
    logic [2:0]  f_req_ready;
    logic        f_busy, f_done, f_adf_sclk, f_adf_data, f_adf_le;
    logic [1:0]  f_done_id;

    assign req_data   = {dw[2], dw[1], dw[0]};
    assign f_req_data = {64'd0, fdw};

    adf4158_write_arbiter #(.NREQ(3), .CLK_DIV(2), .LE_HIGH(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_lock(req_lock), .req_ready(req_ready), .busy(busy), .done(done),
        .done_id(done_id), .adf_sclk(adf_sclk), .adf_data(adf_data), .adf_le(adf_le));

    adf4158_write_arbiter #(.NREQ(3), .CLK_DIV(1), .LE_HIGH(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .req_valid(f_req_valid), .req_data(f_req_data),
        .req_lock(3'b000), .req_ready(f_req_ready), .busy(f_busy), .done(f_done),
        .done_id(f_done_id), .adf_sclk(f_adf_sclk), .adf_data(f_adf_data), .adf_le(f_adf_le));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    int model_last = 2;

    logic [31:0] acc_q[$];
    logic [31:0] cap_q[$];

    function automatic int oh_id(logic [2:0] v);
        if (v == 3'b001) return 0;
        if (v == 3'b010) return 1;
        if (v == 3'b100) return 2;
        return -1;
    endfunction

    // Reference arbitration: first valid requester scanning upward from last+1, wrapping.
    function automatic int rr_pick(logic [2:0] m, int last);
        for (int k = 0; k < 3; k++) begin
            int j;
            j = (last + 1 + k) % 3;
            if (((m >> j) & 3'b001) != 3'b000) return j;
        end
        return -1;
    endfunction

    // Pin-level device model: shift on SCLK rise, latch on LE rise; logs accepted words.
    logic [31:0] sh = 32'd0;
    logic        p_sclk = 1'b0;
    logic        p_le = 1'b1;
    always begin
        @(negedge clk);
        #2;
        if (req_ready != 3'b000 && oh_id(req_ready) >= 0) acc_q.push_back(dw[oh_id(req_ready)]);
        if (adf_sclk === 1'b1 && p_sclk === 1'b0) sh = {sh[30:0], adf_data};
        if (adf_le === 1'b1 && p_le === 1'b0) cap_q.push_back(sh);
        p_sclk = adf_sclk;
        p_le   = adf_le;
    end

    task automatic wait_ready(output int id, output int at);
        #1;
        for (int t = 0; t < 2000; t++) begin
            if (req_ready != 3'b000) begin
                id = oh_id(req_ready);
                at = cyc;
                return;
            end
            @(negedge clk);
            #1;
        end
        id = -1;
        at = -1;
    endtask

    task automatic wait_done(output int at);
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                at = cyc;
                return;
            end
        end
        at = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 3'b111;
        req_lock = 3'b000;
        for (int i = 0; i < 3; i++) dw[i] = $urandom;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 3'b000) $display("FAIL reset_ready got=%b want=000", req_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
        n_checks++; if (done_id !== 2'd0) $display("FAIL reset_done_id got=%0d want=0", done_id); else n_pass++;
        n_checks++; if (adf_sclk !== 1'b0) $display("FAIL reset_sclk got=%b want=0", adf_sclk); else n_pass++;
        n_checks++; if (adf_data !== 1'b0) $display("FAIL reset_data got=%b want=0", adf_data); else n_pass++;
        n_checks++; if (adf_le !== 1'b1) $display("FAIL reset_le got=%b want=1", adf_le); else n_pass++;
        @(negedge clk);
        req_valid = 3'b000;
        rst_n = 1'b1;
        model_last = 2;
        acc_q.delete();
        cap_q.delete();
    endtask

    task automatic test_single();
        int id, c0, k, rises, hi_n, first_hi, viol, done_k;
        logic ps, pd;
        @(negedge clk);
        dw[0] = 32'h8000_0000;
        req_valid = 3'b001;
        wait_ready(id, c0);
        n_checks++; if (id !== 0) $display("FAIL single_grant got=%0d want=0", id); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_at_accept got=%b want=0", busy); else n_pass++;
        model_last = 0;
        @(negedge clk);
        req_valid = 3'b000;
        dw[0] = $urandom;
        #1;
        rises = 0; hi_n = 0; first_hi = -1; viol = 0; done_k = -1; ps = 1'b0; pd = 1'b0;
        for (int t = 0; t < 300 && done_k < 0; t++) begin
            if (t > 0) begin @(negedge clk); #1; end
            k = cyc - c0;
            if (t == 0) begin
                n_checks++; if (busy !== 1'b1 || adf_le !== 1'b0) $display("FAIL single_shift_entry busy=%b le=%b want busy=1 le=0", busy, adf_le); else n_pass++;
            end
            if (adf_sclk && !ps) rises++;
            if (adf_data) begin hi_n++; if (first_hi < 0) first_hi = k; end
            if (t > 0 && adf_sclk && adf_data !== pd) viol++;
            ps = adf_sclk;
            pd = adf_data;
            if (done === 1'b1) begin
                done_k = k;
                n_checks++; if (done_id !== 2'd0) $display("FAIL single_done_id got=%0d want=0", done_id); else n_pass++;
            end
        end
        n_checks++; if (done_k !== 132) $display("FAIL single_latency got=%0d want=132", done_k); else n_pass++;
        n_checks++; if (rises !== 32) $display("FAIL single_sclk_rises got=%0d want=32", rises); else n_pass++;
        n_checks++; if (hi_n !== 4 || first_hi !== 1) $display("FAIL single_data_bit31 high_cycles=%0d first=%0d want 4 and 1", hi_n, first_hi); else n_pass++;
        n_checks++; if (viol !== 0) $display("FAIL single_data_stable got=%0d changes while sclk high want=0", viol); else n_pass++;
        n_checks++; if (cap_q.size() != 1 || cap_q[0] !== 32'h8000_0000) $display("FAIL single_capture n=%0d word=%h want 1 word 80000000", cap_q.size(), cap_q.size() > 0 ? cap_q[0] : 32'h0); else n_pass++;
        acc_q.delete();
        cap_q.delete();
    endtask

    task automatic test_round_robin();
        int grants, dones, last_done, upd, id, expd;
        grants = 0; dones = 0; last_done = -1; upd = -1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) dw[i] = $urandom;
        req_valid = 3'b111;
        for (int t = 0; t < 1200 && dones < 6; t++) begin
            if (t > 0) @(negedge clk);
            if (upd >= 0) begin dw[upd] = $urandom; upd = -1; end
            if (grants >= 6) req_valid = 3'b000;
            #1;
            if (done === 1'b1) begin dones++; last_done = cyc; end
            if (req_ready != 3'b000) begin
                id = oh_id(req_ready);
                expd = (model_last + 1) % 3;
                n_checks++; if (id !== expd) $display("FAIL rr_order grant=%0d got=%0d want=%0d", grants, id, expd); else n_pass++;
                if (last_done >= 0) begin
                    n_checks++; if (cyc !== last_done + 1) $display("FAIL rr_throughput accept_cycle=%0d want=%0d", cyc, last_done + 1); else n_pass++;
                end
                model_last = id;
                grants++;
                upd = id;
            end
        end
        req_valid = 3'b000;
        n_checks++; if (dones !== 6 || grants !== 6) $display("FAIL rr_count grants=%0d dones=%0d want 6 and 6", grants, dones); else n_pass++;
        n_checks++; if (cap_q.size() != acc_q.size() || cap_q.size() != 6) $display("FAIL rr_sb_count got=%0d captured want=%0d", cap_q.size(), acc_q.size()); else n_pass++;
        for (int i = 0; i < cap_q.size() && i < acc_q.size(); i++) begin
            n_checks++; if (cap_q[i] !== acc_q[i]) $display("FAIL rr_sb_word idx=%0d got=%h want=%h", i, cap_q[i], acc_q[i]); else n_pass++;
        end
        acc_q.delete();
        cap_q.delete();
    endtask

    task automatic test_lock();
        int id, at, expd;
        logic [31:0] w;
        @(negedge clk);
        w = $urandom; w[2:0] = 3'd1; dw[1] = w;
        req_valid = 3'b010;
        req_lock = 3'b010;
        wait_ready(id, at);
        expd = rr_pick(3'b010, model_last);
        n_checks++; if (id !== expd) $display("FAIL lock_first got=%0d want=%0d", id, expd); else n_pass++;
        model_last = 1;
        @(negedge clk);
        w = $urandom; w[2:0] = 3'd0; dw[1] = w;
        dw[0] = $urandom;
        dw[2] = $urandom;
        req_valid = 3'b111;
        wait_ready(id, at);
        n_checks++; if (id !== 1) $display("FAIL lock_hold got=%0d want=1", id); else n_pass++;
        @(negedge clk);
        req_lock = 3'b000;
        req_valid = 3'b101;
        wait_ready(id, at);
        expd = rr_pick(3'b101, 1);
        n_checks++; if (id !== expd) $display("FAIL lock_release got=%0d want=%0d", id, expd); else n_pass++;
        model_last = expd;
        @(negedge clk);
        req_valid = 3'b000;
        wait_done(at);
        n_checks++; if (at < 0) $display("FAIL lock_drain got=timeout want=done"); else n_pass++;
        n_checks++; if (cap_q.size() != 3 || acc_q.size() != 3) $display("FAIL lock_sb_count got=%0d/%0d want=3/3", cap_q.size(), acc_q.size()); else n_pass++;
        for (int i = 0; i < cap_q.size() && i < acc_q.size(); i++) begin
            n_checks++; if (cap_q[i] !== acc_q[i]) $display("FAIL lock_sb_word idx=%0d got=%h want=%h", i, cap_q[i], acc_q[i]); else n_pass++;
        end
        @(negedge clk);
        acc_q.delete();
        cap_q.delete();
    endtask

    task automatic test_random();
        int words, cur, drop, id, expd, bad_grant, bad_id;
        logic [2:0] vm;
        words = 0; cur = -1; drop = -1; vm = 3'b000; bad_grant = 0; bad_id = 0;
        for (int t = 0; t < 45000; t++) begin
            @(negedge clk);
            if (drop >= 0) begin vm = vm & ~(3'b001 << drop); drop = -1; end
            for (int i = 0; i < 3; i++) begin
                if (words < 200 && ((vm >> i) & 3'b001) == 3'b000 && $urandom_range(3) == 0) begin
                    vm = vm | (3'b001 << i);
                    dw[i] = $urandom;
                end
            end
            req_valid = vm;
            #1;
            if (done === 1'b1 && int'(done_id) != cur) bad_id++;
            if (req_ready != 3'b000) begin
                id = oh_id(req_ready);
                expd = rr_pick(req_valid, model_last);
                if (id != expd) begin
                    bad_grant++;
                    if (bad_grant <= 3) $display("FAIL rand_grant word=%0d got=%b want=%0d", words, req_ready, expd);
                end
                model_last = id;
                cur = id;
                words++;
                drop = id;
            end
            if (words >= 200 && vm == 3'b000 && drop < 0 && !busy) break;
        end
        req_valid = 3'b000;
        n_checks++; if (words < 200) $display("FAIL rand_progress got=%0d words want>=200", words); else n_pass++;
        n_checks++; if (bad_grant !== 0) $display("FAIL rand_arbitration got=%0d wrong grants want=0", bad_grant); else n_pass++;
        n_checks++; if (bad_id !== 0) $display("FAIL rand_done_id got=%0d wrong ids want=0", bad_id); else n_pass++;
        n_checks++; if (cap_q.size() != acc_q.size()) $display("FAIL rand_sb_count got=%0d want=%0d", cap_q.size(), acc_q.size()); else n_pass++;
        for (int i = 0; i < cap_q.size() && i < acc_q.size(); i++) begin
            n_checks++; if (cap_q[i] !== acc_q[i]) $display("FAIL rand_sb_word idx=%0d got=%h want=%h", i, cap_q[i], acc_q[i]); else n_pass++;
        end
        acc_q.delete();
        cap_q.delete();
    endtask

    task automatic test_reset_mid();
        int id, c0, at, expd, seen_done;
        seen_done = 0;
        @(negedge clk);
        dw[0] = $urandom;
        req_valid = 3'b001;
        wait_ready(id, c0);
        expd = rr_pick(3'b001, model_last);
        n_checks++; if (id !== expd) $display("FAIL rstmid_grant got=%0d want=%0d", id, expd); else n_pass++;
        model_last = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            req_valid = 3'b000;
            if (cyc - c0 >= 40) begin
                rst_n = 1'b0;
                for (int i = 0; i < 3; i++) dw[i] = $urandom;
                req_valid = 3'b111;
                #1;
                if (done === 1'b1) seen_done = 1;
                break;
            end
            #1;
            if (done === 1'b1) seen_done = 1;
        end
        @(negedge clk);
        #1;
        n_checks++; if (adf_le !== 1'b1 || adf_sclk !== 1'b0) $display("FAIL rstmid_pins le=%b sclk=%b want le=1 sclk=0", adf_le, adf_sclk); else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_state busy=%b done=%b want 0 0", busy, done); else n_pass++;
        n_checks++; if (req_ready !== 3'b000) $display("FAIL rstmid_ready_in_reset got=%b want=000", req_ready); else n_pass++;
        n_checks++; if (seen_done !== 0) $display("FAIL rstmid_no_done got=done_pulse want=none"); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (req_ready !== 3'b001) $display("FAIL rstmid_first_after_reset got=%b want=001", req_ready); else n_pass++;
        model_last = 0;
        acc_q.delete();
        cap_q.delete();
        @(negedge clk);
        req_valid = 3'b000;
        wait_done(at);
        n_checks++; if (cap_q.size() != 1 || acc_q.size() != 1 || cap_q[0] !== acc_q[0]) $display("FAIL rstmid_next_word got=%h want=%h", cap_q.size() > 0 ? cap_q[0] : 32'h0, acc_q.size() > 0 ? acc_q[0] : 32'h0); else n_pass++;
        @(negedge clk);
        acc_q.delete();
        cap_q.delete();
    endtask

    task automatic test_fast();
        int c0, k, done_k, bad, rises;
        logic [31:0] w, fsh;
        logic ps;
        c0 = -1; done_k = -1; bad = 0; rises = 0; fsh = 32'd0; ps = 1'b0;
        @(negedge clk);
        w = $urandom;
        fdw = w;
        f_req_valid = 3'b001;
        #1;
        for (int t = 0; t < 50 && c0 < 0; t++) begin
            if (f_req_ready === 3'b001) c0 = cyc;
            else begin @(negedge clk); #1; end
        end
        n_checks++; if (c0 < 0) $display("FAIL fast_accept got=timeout want=ready"); else n_pass++;
        @(negedge clk);
        f_req_valid = 3'b000;
        fdw = ~w;
        #1;
        for (int t = 0; t < 200 && done_k < 0 && c0 >= 0; t++) begin
            if (t > 0) begin @(negedge clk); #1; end
            k = cyc - c0;
            if (k >= 1 && k <= 64 && f_adf_sclk !== 1'((k - 1) % 2)) bad++;
            if (f_adf_sclk && !ps) begin rises++; fsh = {fsh[30:0], f_adf_data}; end
            ps = f_adf_sclk;
            if (f_done === 1'b1) done_k = k;
        end
        n_checks++; if (done_k !== 66) $display("FAIL fast_latency got=%0d want=66", done_k); else n_pass++;
        n_checks++; if (bad !== 0 || rises !== 32) $display("FAIL fast_sclk_toggle bad=%0d rises=%0d want 0 and 32", bad, rises); else n_pass++;
        n_checks++; if (fsh !== w) $display("FAIL fast_word got=%h want=%h", fsh, w); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) dw[i] = 32'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_random();
        test_reset_mid();
        test_fast();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=bench_complete");
        $fatal(1, "watchdog expired");
    end

endmodule
